// File: rtl/truth_table_scanner_if.sv
// Bundle of signals between truth_table_scanner and its environment.
//
// Parameter:
//   N          number of function inputs (1..4)
// Signals:
//   start      pulse to begin a scan (environment -> scanner)
//   vars       current input combination driven to the functions under test
//   f_a, f_b   outputs of the two implementations being compared
//   busy       high while a scan is running
//   done       one-cycle pulse when results become valid
//   minterms   bit i = f_a at vars==i
//   maxterms   bit i = ~f_a at vars==i
//   ones       population count of minterms
//   equal      f_a matched f_b at every index of the last scan
//   first_diff lowest mismatching index (meaningful only when equal==0)
//
// Handshake: start is a level sampled on the rising clock edge and takes
// effect only while the scanner is idle; done is a single-cycle pulse that
// needs no acknowledge, and results remain stable until the next accepted
// start.
interface truth_table_scanner_if #(
    parameter int N = 2
);
    logic              start;
    logic [N-1:0]      vars;
    logic              f_a;
    logic              f_b;
    logic              busy;
    logic              done;
    logic [(1<<N)-1:0] minterms;
    logic [(1<<N)-1:0] maxterms;
    logic [N:0]        ones;
    logic              equal;
    logic [N-1:0]      first_diff;

    // Environment side: issues start, supplies function outputs.
    modport master (
        output start, f_a, f_b,
        input  vars, busy, done, minterms, maxterms, ones, equal, first_diff
    );

    // Scanner side.
    modport slave (
        input  start, f_a, f_b,
        output vars, busy, done, minterms, maxterms, ones, equal, first_diff
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Sequential truth-table extractor. Steps vars through 0 .. 2^N-1, waits
// SETTLE idle cycles at each combination, samples f_a and f_b, and builds
// the minterm/maxterm lists, the count of ones, and an equivalence flag with
// the lowest mismatching index.
//
// Parameters:
//   N          number of function inputs (1..4)
//   SETTLE     idle cycles between driving vars and sampling (0..15)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        truth_table_scanner_if slave modport (start, vars, f_a, f_b,
//              busy, done, minterms, maxterms, ones, equal, first_diff)
//   state_dbg  current FSM state, for observation only
module truth_table_scanner #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    truth_table_scanner_if.slave         bus,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0]   SETTLE_V = 4'(SETTLE);
    localparam logic [N-1:0] LAST     = {N{1'b1}};
    localparam logic [N-1:0] ONE      = N'(1);

    state_t            state;
    logic [3:0]        cnt;
    logic [N-1:0]      vars;
    logic              busy;
    logic              done;
    logic [(1<<N)-1:0] minterms;
    logic [(1<<N)-1:0] maxterms;
    logic [N:0]        ones;
    logic              equal;
    logic [N-1:0]      first_diff;

    // When there is no settle time the scanner goes straight from driving a
    // combination to sampling it on the next edge.
    localparam state_t AFTER_DRIVE = (SETTLE == 0) ? SAMPLE : WAIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            vars       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            minterms   <= '0;
            maxterms   <= '0;
            ones       <= '0;
            equal      <= 1'b0;
            first_diff <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy       <= 1'b1;
                        vars       <= '0;
                        minterms   <= '0;
                        maxterms   <= '0;
                        ones       <= '0;
                        equal      <= 1'b1;
                        first_diff <= '0;
                        cnt        <= SETTLE_V;
                        state      <= AFTER_DRIVE;
                    end
                end

                WAIT: begin
                    // Counter reading 1 means this is the last idle cycle.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    minterms[vars] <= bus.f_a;
                    maxterms[vars] <= ~bus.f_a;
                    ones           <= ones + (N+1)'(bus.f_a);
                    // Only the first mismatch is recorded.
                    if ((bus.f_a != bus.f_b) && equal) begin
                        equal      <= 1'b0;
                        first_diff <= vars;
                    end
                    if (vars == LAST) begin
                        vars  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        vars  <= vars + ONE;
                        cnt   <= SETTLE_V;
                        state <= AFTER_DRIVE;
                    end
                end

                FINISH: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.vars       = vars;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.minterms   = minterms;
    assign bus.maxterms   = maxterms;
    assign bus.ones       = ones;
    assign bus.equal      = equal;
    assign bus.first_diff = first_diff;
    assign state_dbg      = state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner. Three instances cover
// N=2/SETTLE=1, N=2/SETTLE=0 and N=3/SETTLE=2. Each function under test is a
// truth table held in the bench and indexed by the DUT's vars output.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    truth_table_scanner_if #(.N(2)) if0 ();
    truth_table_scanner_if #(.N(2)) if1 ();
    truth_table_scanner_if #(.N(3)) if2 ();

    logic [1:0] st0, st1, st2;

    // Truth tables for f_a and f_b of each instance (bit i = value at index i).
    logic [7:0] tta [3];
    logic [7:0] ttb [3];

    truth_table_scanner #(.N(2), .SETTLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_dbg(st0));
    truth_table_scanner #(.N(2), .SETTLE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg(st1));
    truth_table_scanner #(.N(3), .SETTLE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_dbg(st2));

    assign if0.f_a = tta[0][if0.vars];
    assign if0.f_b = ttb[0][if0.vars];
    assign if1.f_a = tta[1][if1.vars];
    assign if1.f_b = ttb[1][if1.vars];
    assign if2.f_a = tta[2][if2.vars];
    assign if2.f_b = ttb[2][if2.vars];

    // ---------------- reference model ----------------
    function automatic int num_inputs(int w);
        return (w == 2) ? 3 : 2;
    endfunction

    function automatic int settle_of(int w);
        return (w == 0) ? 1 : ((w == 1) ? 0 : 2);
    endfunction

    function automatic int ref_latency(int w);
        return (1 << num_inputs(w)) * (settle_of(w) + 1);
    endfunction

    function automatic logic [7:0] ref_mask(int w);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < (1 << num_inputs(w)); i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int ref_first_diff(logic [7:0] a, logic [7:0] b, int size);
        for (int i = 0; i < size; i++) if (a[i] != b[i]) return i;
        return 0;
    endfunction

    // ---------------- driver helpers ----------------
    function automatic logic dut_done(int w);
        case (w)
            0: return if0.done;
            1: return if1.done;
            default: return if2.done;
        endcase
    endfunction

    task automatic set_start(int w, logic v);
        case (w)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Pulses start on instance w, waits for done (bounded), then watches a
    // few more cycles for extra done pulses. Captures results zero-extended.
    task automatic scan_any(input int w, output int lat, output int pulses,
                            output logic [7:0] mn, output logic [7:0] mx,
                            output logic [3:0] on, output logic eq,
                            output logic [2:0] fd);
        lat = -1;
        pulses = 0;
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (dut_done(w)) begin
                lat = c;
                pulses = 1;
                break;
            end
        end
        case (w)
            0: begin mn = 8'(if0.minterms); mx = 8'(if0.maxterms); on = 4'(if0.ones); eq = if0.equal; fd = 3'(if0.first_diff); end
            1: begin mn = 8'(if1.minterms); mx = 8'(if1.maxterms); on = 4'(if1.ones); eq = if1.equal; fd = 3'(if1.first_diff); end
            default: begin mn = 8'(if2.minterms); mx = 8'(if2.maxterms); on = 4'(if2.ones); eq = if2.equal; fd = 3'(if2.first_diff); end
        endcase
        repeat (4) begin
            @(negedge clk);
            if (dut_done(w)) pulses++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.vars, if0.busy, if0.done, if0.minterms, if0.maxterms, if0.ones, if0.equal, if0.first_diff} !== '0) begin
            errors++; $display("FAIL reset_u0: outputs not all zero");
        end
        checks++;
        if ({if1.vars, if1.busy, if1.done, if1.minterms, if1.maxterms, if1.ones, if1.equal, if1.first_diff} !== '0) begin
            errors++; $display("FAIL reset_u1: outputs not all zero");
        end
        checks++;
        if ({if2.vars, if2.busy, if2.done, if2.minterms, if2.maxterms, if2.ones, if2.equal, if2.first_diff} !== '0) begin
            errors++; $display("FAIL reset_u2: outputs not all zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_equivalence();
        int lat, pulses;
        logic [7:0] mn, mx;
        logic [3:0] on;
        logic eq;
        logic [2:0] fd;
        tta[0] = 8'b0101;  // ~y
        ttb[0] = 8'b0101;
        scan_any(0, lat, pulses, mn, mx, on, eq, fd);
        checks++; if (lat !== 8) begin errors++; $display("FAIL equiv_latency: got %0d exp 8", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL equiv_pulses: got %0d exp 1", pulses); end
        checks++; if (mn !== 8'b0101) begin errors++; $display("FAIL equiv_minterms: got %b exp 0101", mn); end
        checks++; if (mx !== 8'b1010) begin errors++; $display("FAIL equiv_maxterms: got %b exp 1010", mx); end
        checks++; if (on !== 4'd2) begin errors++; $display("FAIL equiv_ones: got %0d exp 2", on); end
        checks++; if (eq !== 1'b1) begin errors++; $display("FAIL equiv_equal: got %b exp 1", eq); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL equiv_busy_after: got %b exp 0", if0.busy); end
    endtask

    task automatic test_mismatch();
        int lat, pulses;
        logic [7:0] mn, mx;
        logic [3:0] on;
        logic eq;
        logic [2:0] fd;
        tta[0] = 8'b0101;  // ~y
        ttb[0] = 8'b0011;  // ~x
        scan_any(0, lat, pulses, mn, mx, on, eq, fd);
        checks++; if (mn !== 8'b0101) begin errors++; $display("FAIL mismatch_minterms: got %b exp 0101", mn); end
        checks++; if (eq !== 1'b0) begin errors++; $display("FAIL mismatch_equal: got %b exp 0", eq); end
        checks++; if (fd !== 3'd1) begin errors++; $display("FAIL mismatch_first_diff: got %0d exp 1", fd); end
    endtask

    task automatic test_zero_settle();
        tta[1] = 8'b1111;
        ttb[1] = 8'b1111;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (if1.vars !== 2'(k) || if1.done !== 1'b0) begin
                errors++; $display("FAIL zero_settle_step%0d: vars=%0d done=%b exp vars=%0d done=0", k, if1.vars, if1.done, k);
            end
            @(negedge clk);
        end
        checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL zero_settle_done: got %b exp 1 at cycle 4", if1.done); end
        checks++; if (if1.minterms !== 4'b1111) begin errors++; $display("FAIL zero_settle_minterms: got %b exp 1111", if1.minterms); end
        checks++; if (if1.ones !== 3'd4) begin errors++; $display("FAIL zero_settle_ones: got %0d exp 4", if1.ones); end
        checks++; if (if1.equal !== 1'b1) begin errors++; $display("FAIL zero_settle_equal: got %b exp 1", if1.equal); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat = -1;
        int pulses = 0;
        bit injected = 0;
        tta[0] = 8'b0101;
        ttb[0] = 8'b0101;
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (if0.done) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (if0.start) if0.start = 1'b0;
            else if (!injected && if0.busy && if0.vars == 2'd2) begin
                if0.start = 1'b1;
                injected = 1;
            end
        end
        checks++; if (!injected) begin errors++; $display("FAIL busy_inject: index 2 never observed"); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL busy_latency: got %0d exp 8", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d exp 1", pulses); end
        checks++; if (if0.minterms !== 4'b0101 || if0.ones !== 3'd2 || if0.equal !== 1'b1) begin
            errors++; $display("FAIL busy_results: got min=%b ones=%0d eq=%b exp 0101/2/1", if0.minterms, if0.ones, if0.equal);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, pulses;
        int extra = 0;
        bool_found: begin end
        begin
            logic [7:0] mn, mx;
            logic [3:0] on;
            logic eq;
            logic [2:0] fd;
            bit found = 0;
            tta[0] = 8'b0101;
            ttb[0] = 8'b0101;
            @(negedge clk);
            if0.start = 1'b1;
            @(negedge clk);
            if0.start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (if0.vars == 2'd1) begin found = 1; break; end
            end
            checks++; if (!found || if0.busy !== 1'b1) begin errors++; $display("FAIL rstmid_reach: found=%0d busy=%b exp 1/1", found, if0.busy); end
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if ({if0.vars, if0.busy, if0.done, if0.minterms, if0.maxterms, if0.ones, if0.equal, if0.first_diff} !== '0) begin
                errors++; $display("FAIL rstmid_clear: outputs not all zero after async reset");
            end
            @(negedge clk);
            rst_n = 1'b1;
            repeat (12) begin
                @(negedge clk);
                if (if0.done || if0.busy) extra++;
            end
            checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles exp 0", extra); end
            scan_any(0, lat, pulses, mn, mx, on, eq, fd);
            checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_latency: got %0d exp 8", lat); end
            checks++; if (mn !== 8'b0101 || mx !== 8'b1010 || on !== 4'd2 || eq !== 1'b1) begin
                errors++; $display("FAIL rstmid_results: got min=%b max=%b ones=%0d eq=%b", mn, mx, on, eq);
            end
        end
    endtask

    task automatic test_majority();
        int lat, pulses;
        logic [7:0] mn, mx;
        logic [3:0] on;
        logic eq;
        logic [2:0] fd;
        for (int i = 0; i < 8; i++) begin
            tta[2][i] = ($countones(i[2:0]) >= 2);
        end
        ttb[2] = tta[2];
        scan_any(2, lat, pulses, mn, mx, on, eq, fd);
        checks++; if (lat !== 24) begin errors++; $display("FAIL maj_latency: got %0d exp 24", lat); end
        checks++; if (mn !== 8'b11101000) begin errors++; $display("FAIL maj_minterms: got %b exp 11101000", mn); end
        checks++; if (mx !== 8'b00010111) begin errors++; $display("FAIL maj_maxterms: got %b exp 00010111", mx); end
        checks++; if (on !== 4'd4) begin errors++; $display("FAIL maj_ones: got %0d exp 4", on); end
        checks++; if (eq !== 1'b1) begin errors++; $display("FAIL maj_equal: got %b exp 1", eq); end
    endtask

    task automatic test_back_to_back();
        int gap = -1;
        bit seen = 0;
        tta[0] = 8'b0110;
        ttb[0] = 8'b1110;
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if0.done) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_done: timeout"); end
        // Hold start through the FINISH edge (ignored) and the next one (accepted).
        tta[0] = 8'b1001;
        ttb[0] = 8'b1001;
        if0.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        for (int c = 3; c <= 40; c++) begin
            @(negedge clk);
            if (if0.done) begin gap = c; break; end
        end
        checks++; if (gap !== 10) begin errors++; $display("FAIL b2b_period: got %0d exp 10", gap); end
        checks++; if (if0.minterms !== 4'b1001 || if0.equal !== 1'b1 || if0.ones !== 3'd2) begin
            errors++; $display("FAIL b2b_results: got min=%b eq=%b ones=%0d exp 1001/1/2", if0.minterms, if0.equal, if0.ones);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int lat, pulses, size;
        logic [7:0] mn, mx, mask, ea;
        logic [3:0] on;
        logic eq, exp_eq;
        logic [2:0] fd;
        for (int it = 0; it < 12; it++) begin
            int w = it % 3;
            size = 1 << num_inputs(w);
            mask = ref_mask(w);
            tta[w] = 8'($urandom) & mask;
            ttb[w] = ($urandom_range(0, 1) == 1) ? tta[w] : (8'($urandom) & mask);
            ea = tta[w];
            exp_eq = (tta[w] == ttb[w]);
            scan_any(w, lat, pulses, mn, mx, on, eq, fd);
            checks++; if (lat !== ref_latency(w) || pulses !== 1) begin
                errors++; $display("FAIL rand%0d_timing: lat=%0d pulses=%0d exp %0d/1", it, lat, pulses, ref_latency(w));
            end
            checks++; if (mn !== ea || mx !== (~ea & mask)) begin
                errors++; $display("FAIL rand%0d_terms: min=%h max=%h exp %h/%h", it, mn, mx, ea, ~ea & mask);
            end
            checks++; if (on !== 4'($countones(ea))) begin
                errors++; $display("FAIL rand%0d_ones: got %0d exp %0d", it, on, $countones(ea));
            end
            checks++; if (eq !== exp_eq) begin
                errors++; $display("FAIL rand%0d_equal: got %b exp %b", it, eq, exp_eq);
            end
            if (!exp_eq) begin
                checks++; if (fd !== 3'(ref_first_diff(tta[w], ttb[w], size))) begin
                    errors++; $display("FAIL rand%0d_first_diff: got %0d exp %0d", it, fd, ref_first_diff(tta[w], ttb[w], size));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tta[i] = 8'h00;
            ttb[i] = 8'h00;
        end
        test_reset();
        test_equivalence();
        test_mismatch();
        test_zero_settle();
        test_start_while_busy();
        test_reset_mid_scan();
        test_majority();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
